// File: rtl/regfile_param.sv
// Parametrised 2R/1W register file with registered and combinational read ports and a pending scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_param #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [AW-1:0]    addra,
   output logic [WIDTH-1:0] dataa,
   output logic [WIDTH-1:0] ass_dataa,
   output logic             pend_a,
   input  logic [AW-1:0]    addrb,
   output logic [WIDTH-1:0] datab,
   output logic [WIDTH-1:0] ass_datab,
   output logic             pend_b,
   input  logic             enc,
   input  logic [AW-1:0]    addrc,
   input  logic [WIDTH-1:0] datac,
   input  logic             set_en,
   input  logic [AW-1:0]    set_addr,
   input  logic [AW-1:0]    addrout,
   output logic [WIDTH-1:0] regout
);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] pend;
   logic [DEPTH-1:0] pend_nxt;
   logic             wr_ok;
   logic             set_ok;
   logic             hit_a;
   logic             hit_b;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;

   // Register 0 is never written nor marked pending, so it always reads zero.
   assign wr_ok  = enc    && !((ZERO_REG != 0) && (addrc    == '0));
   assign set_ok = set_en && !((ZERO_REG != 0) && (set_addr == '0));

`ifdef REGFILE_BYPASS_EN
   assign hit_a = wr_ok && (addrc == addra);
   assign hit_b = wr_ok && (addrc == addrb);
`else
   assign hit_a = 1'b0;
   assign hit_b = 1'b0;
`endif

   // Set is applied after the write-clear so it wins on the same address.
   always_comb begin
      pend_nxt = pend;
      if (wr_ok)
         pend_nxt[addrc] = 1'b0;
      if (set_ok)
         pend_nxt[set_addr] = 1'b1;
   end

   assign rd_a      = hit_a ? datac : regs[addra];
   assign rd_b      = hit_b ? datac : regs[addrb];
   assign ass_dataa = rd_a;
   assign ass_datab = rd_b;
   assign regout    = regs[addrout];
   assign pend_a    = hit_a ? (set_ok && (set_addr == addra)) : pend[addra];
   assign pend_b    = hit_b ? (set_ok && (set_addr == addrb)) : pend[addrb];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            regs[i] <= '0;
         pend  <= '0;
         dataa <= '0;
         datab <= '0;
      end else begin
         if (wr_ok)
            regs[addrc] <= datac;
         pend  <= pend_nxt;
         dataa <= rd_a;
         datab <= rd_b;
      end
   end

endmodule
